// File: rtl/cdc_sync_filter.sv
// Multi-channel level synchroniser with per-channel debounce filter and registered rise/fall/any-change pulses.
// Latency: a stable input change sampled at edge 1 reaches out_data at edge STAGES+FILTER; pulses on that same edge.
// Backpressure: none; free-running level path, every channel independent, rst is synchronous active-high.
module cdc_sync_filter #(
    parameter int             N      = 1,
    parameter int             STAGES = 2,
    parameter int             FILTER = 1,
    parameter logic [N-1:0]   INIT   = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] out_data,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_change
);

    localparam int            CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("cdc_sync_filter: STAGES must be at least 2");
    end
    if (FILTER < 1) begin : g_bad_filter
        $error("cdc_sync_filter: FILTER must be at least 1");
    end

    logic [N-1:0] sync_vec;
    logic [N-1:0] upd_vec;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [STAGES-1:0] chain;
        logic [CW-1:0]     cnt;
        logic              differs;

        // Plain flop chain, nothing combinational between stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                chain <= {STAGES{INIT[i]}};
            end else begin
                chain <= {chain[STAGES-2:0], in_data[i]};
            end
        end

        assign sync_vec[i] = chain[STAGES-1];
        assign differs     = (chain[STAGES-1] != out_data[i]);
        assign upd_vec[i]  = differs && (cnt == CNT_LAST);

        // Any agreement with out_data discards a partial count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (!differs || upd_vec[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= INIT;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            out_data   <= (out_data & ~upd_vec) | (sync_vec & upd_vec);
            rise       <= upd_vec & sync_vec;
            fall       <= upd_vec & ~sync_vec;
            any_change <= |upd_vec;
        end
    end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Bench for cdc_sync_filter: four configurations driven side by side, checked every cycle
// against a sample-window reference model plus directed latency/glitch/reset scenarios.
module tb_cdc_sync_filter;

    localparam int NI = 4;
    localparam int HD = 16;
    localparam int P_N    [NI] = '{4, 1, 2, 1};
    localparam int P_S    [NI] = '{2, 2, 2, 3};
    localparam int P_F    [NI] = '{1, 4, 1, 3};
    localparam int P_INIT [NI] = '{0, 0, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_v [NI];

    always #5 clk = ~clk;

    logic [3:0] o0, r0, f0;
    logic       a0;
    logic [0:0] o1, r1, f1;
    logic       a1;
    logic [1:0] o2, r2, f2;
    logic       a2;
    logic [0:0] o3, r3, f3;
    logic       a3;

    cdc_sync_filter #(.N(4), .STAGES(2), .FILTER(1), .INIT(4'h0)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_v[0][3:0]),
        .out_data(o0), .rise(r0), .fall(f0), .any_change(a0));
    cdc_sync_filter #(.N(1), .STAGES(2), .FILTER(4), .INIT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_v[1][0:0]),
        .out_data(o1), .rise(r1), .fall(f1), .any_change(a1));
    cdc_sync_filter #(.N(2), .STAGES(2), .FILTER(1), .INIT(2'b10)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_v[2][1:0]),
        .out_data(o2), .rise(r2), .fall(f2), .any_change(a2));
    cdc_sync_filter #(.N(1), .STAGES(3), .FILTER(3), .INIT(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_v[3][0:0]),
        .out_data(o3), .rise(r3), .fall(f3), .any_change(a3));

    logic [3:0] g_out [NI], g_rise [NI], g_fall [NI];
    logic       g_any [NI];

    always_comb begin
        g_out[0] = o0;          g_rise[0] = r0;          g_fall[0] = f0;          g_any[0] = a0;
        g_out[1] = {3'b0, o1};  g_rise[1] = {3'b0, r1};  g_fall[1] = {3'b0, f1};  g_any[1] = a1;
        g_out[2] = {2'b0, o2};  g_rise[2] = {2'b0, r2};  g_fall[2] = {2'b0, f2};  g_any[2] = a2;
        g_out[3] = {3'b0, o3};  g_rise[3] = {3'b0, r3};  g_fall[3] = {3'b0, f3};  g_any[3] = a3;
    end

    int checks = 0;
    int errors = 0;

    // Reference state: samp[k][0] is the input sampled at the most recent edge.
    logic [3:0] e_out [NI], e_rise [NI], e_fall [NI];
    logic       e_any [NI];
    logic [3:0] samp [NI][HD];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A bit flips once the last FILTER synchronised samples all disagree with the current output;
    // the sample seen by the filter at this edge was taken STAGES edges earlier.
    task automatic model_step(input int k);
        logic [3:0] nout;
        logic       flip;
        if (rst) begin
            e_out[k]  = 4'(P_INIT[k]);
            e_rise[k] = '0;
            e_fall[k] = '0;
            e_any[k]  = 1'b0;
            for (int d = 0; d < HD; d++) samp[k][d] = 4'(P_INIT[k]);
        end else begin
            nout = e_out[k];
            for (int b = 0; b < P_N[k]; b++) begin
                flip = 1'b1;
                for (int j = 0; j < P_F[k]; j++)
                    if (samp[k][P_S[k] - 1 + j][b] == e_out[k][b]) flip = 1'b0;
                if (flip) nout[b] = ~e_out[k][b];
            end
            e_rise[k] = nout & ~e_out[k];
            e_fall[k] = ~nout & e_out[k];
            e_any[k]  = (nout != e_out[k]);
            e_out[k]  = nout;
            for (int d = HD - 1; d > 0; d--) samp[k][d] = samp[k][d-1];
            samp[k][0] = in_v[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("out[%0d]", k),  g_out[k],  e_out[k]);
            check_val($sformatf("rise[%0d]", k), g_rise[k], e_rise[k]);
            check_val($sformatf("fall[%0d]", k), g_fall[k], e_fall[k]);
            check_val($sformatf("any[%0d]", k),  g_any[k],  e_any[k]);
        end
    endtask

    int pulses;

    initial begin
        for (int k = 0; k < NI; k++) begin
            e_out[k] = '0; e_rise[k] = '0; e_fall[k] = '0; e_any[k] = 1'b0;
            for (int d = 0; d < HD; d++) samp[k][d] = '0;
        end
        rst     = 1'b1;
        in_v[0] = 4'h0;
        in_v[1] = 4'h0;
        in_v[2] = 4'h2;
        in_v[3] = 4'h1;
        tick();
        tick();
        check_val("rst_out0", o0, 4'h0);
        check_val("rst_out2", o2, 2'b10);
        check_val("rst_out3", o3, 1'b1);
        check_val("rst_any0", a0, 1'b0);

        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(a2) + int'(a3);
        end
        check_val("release_pulses", pulses, 0);

        // 4-channel, no filter: 0x5 sampled at edge 1 lands at edge 3.
        in_v[0] = 4'h5;
        tick();
        tick();
        check_val("lat_e2_out", o0, 4'h0);
        tick();
        check_val("lat_e3_out", o0, 4'h5);
        check_val("lat_e3_rise", r0, 4'h5);
        check_val("lat_e3_any", a0, 1'b1);
        tick();
        check_val("lat_e4_rise", r0, 4'h0);
        check_val("lat_e4_any", a0, 1'b0);

        // Simultaneous rise and fall on two channels.
        in_v[2] = 4'h1;
        repeat (3) tick();
        check_val("simul_rise", r2, 2'b01);
        check_val("simul_fall", f2, 2'b10);
        check_val("simul_any", a2, 1'b1);
        tick();
        check_val("simul_any_off", a2, 1'b0);

        // INIT=1 channel falls at edge STAGES+FILTER = 6.
        in_v[3] = 4'h0;
        repeat (5) tick();
        check_val("init1_e5_fall", f3, 1'b0);
        tick();
        check_val("init1_e6_fall", f3, 1'b1);
        check_val("init1_e6_out", o3, 1'b0);

        // FILTER=4: a 3-cycle high pulse is rejected.
        in_v[1] = 4'h1;
        repeat (3) tick();
        in_v[1] = 4'h0;
        pulses = 0;
        repeat (8) begin
            tick();
            pulses += int'(r1);
        end
        check_val("glitch_rise", pulses, 0);
        check_val("glitch_out", o1, 1'b0);

        in_v[1] = 4'h1;
        repeat (5) tick();
        check_val("f4_e5_out", o1, 1'b0);
        tick();
        check_val("f4_e6_out", o1, 1'b1);
        check_val("f4_e6_rise", r1, 1'b1);
        tick();
        check_val("f4_e7_rise", r1, 1'b0);
        in_v[1] = 4'h0;
        repeat (5) tick();
        check_val("f4_fall_e5", f1, 1'b0);
        tick();
        check_val("f4_fall_e6", f1, 1'b1);

        // Reset in the middle of a filter count restarts the full latency.
        in_v[1] = 4'h1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_val("midrst_out", o1, 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        check_val("midrst_e5_out", o1, 1'b0);
        tick();
        check_val("midrst_e6_out", o1, 1'b1);
        check_val("midrst_e6_rise", r1, 1'b1);

        // FILTER=3 channel toggling every cycle never updates.
        repeat (4) tick();
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            in_v[3][0] = ~in_v[3][0];
            tick();
            pulses += int'(r3) + int'(f3) + int'(a3);
        end
        check_val("toggle_pulses", pulses, 0);
        check_val("toggle_out", o3, 1'b0);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < NI; k++)
                if ($urandom_range(0, 3) == 0) in_v[k] = 4'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
